uart_rx_core: RTL and testbench

Receive-side UART engine paired with the existing transmitter, using the same 16x oversampling tick (s_tick) from the shared baud generator. It synchronizes the asynchronous rx line, detects and validates the start bit, samples each data bit at mid-bit, and checks the stop bit. It presents each received byte with a one-cycle completion strobe and a framing-error flag. It sits between the board pin (or the transmitter's tx in loopback) and the host-side consumer.

---
 rtl/uart_rx_core_if.sv | 45 ++++
 rtl/uart_rx_core.sv | 173 +++++++++++++++++
 tb/tb_uart_rx_core.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_core_if.sv
// -----------------------------------------------------------------------------
// uart_rx_core_if
//   Groups the serial-side inputs and the host-side results of the UART
//   receiver into one bundle.
//
//   Signals
//     rx         serial line into the receiver (idle level 1, asynchronous)
//     s_tick     one-clk pulse at 16x the baud rate from the shared generator
//     dataout    last received data word, held until the next frame completes
//     rx_done    one-clk pulse when a frame completes (good or bad)
//     frame_err  stop bit sampled as 0; valid with rx_done, held until next
//     rx_busy    receiver is somewhere other than idle
//
//   Modports
//     slave      the receiver core itself
//     master     whatever drives the line/tick and consumes the results
// -----------------------------------------------------------------------------
interface uart_rx_core_if #(
   parameter int DBIT = 8
) ();
   logic            rx;
   logic            s_tick;
   logic [DBIT-1:0] dataout;
   logic            rx_done;
   logic            frame_err;
   logic            rx_busy;

   modport slave (
      input  rx,
      input  s_tick,
      output dataout,
      output rx_done,
      output frame_err,
      output rx_busy
   );

   modport master (
      output rx,
      output s_tick,
      input  dataout,
      input  rx_done,
      input  frame_err,
      input  rx_busy
   );
endinterface

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
//   Receive-side UART engine using the 16x oversampling tick. The rx line is
//   brought into the clk domain by a 2-flop synchronizer; a start bit is
//   confirmed at its middle, each data bit is sampled at mid-bit (LSB first)
//   and the stop bit is checked after SB_TICK ticks. Every completed frame
//   gives a one-clk rx_done together with dataout and frame_err.
//
//   Parameters
//     DBIT     data bits per frame, 5..8
//     SB_TICK  s_tick count for the stop phase (16, 24 or 32)
//
//   Ports
//     clk      system clock, rising edge
//     reset    asynchronous, active-high
//     bus      uart_rx_core_if.slave: rx, s_tick in; dataout, rx_done,
//              frame_err, rx_busy out
// -----------------------------------------------------------------------------
module uart_rx_core #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input  logic          clk,
   input  logic          reset,
   uart_rx_core_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   // The sample counter is 5 bits so the stop phase can run up to 32 ticks;
   // start and data phases never let it exceed 15.
   localparam logic [4:0] C_MID_START = 5'd7;
   localparam logic [4:0] C_BIT_LAST  = 5'd15;
   localparam logic [4:0] C_STOP_LAST = 5'(SB_TICK - 1);
   localparam logic [2:0] C_LAST_BIT  = 3'(DBIT - 1);

   logic            r_rx_meta;
   logic            r_rx_s;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [4:0]      r_s_cnt;
   logic [4:0]      w_s_cnt_nxt;
   logic [2:0]      r_n_cnt;
   logic [2:0]      w_n_cnt_nxt;
   logic [DBIT-1:0] r_shreg;
   logic [DBIT-1:0] w_shreg_nxt;
   logic [DBIT-1:0] r_dataout;
   logic [DBIT-1:0] w_dataout_nxt;
   logic            r_rx_done;
   logic            w_rx_done_nxt;
   logic            r_frame_err;
   logic            w_frame_err_nxt;

   // Synchronizer resets to the idle level so no false start is seen
   // coming out of reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         r_rx_meta <= bus.rx;
         r_rx_s    <= r_rx_meta;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_s_cnt     <= '0;
         r_n_cnt     <= '0;
         r_shreg     <= '0;
         r_dataout   <= '0;
         r_rx_done   <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_s_cnt     <= w_s_cnt_nxt;
         r_n_cnt     <= w_n_cnt_nxt;
         r_shreg     <= w_shreg_nxt;
         r_dataout   <= w_dataout_nxt;
         r_rx_done   <= w_rx_done_nxt;
         r_frame_err <= w_frame_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_s_cnt_nxt     = r_s_cnt;
      w_n_cnt_nxt     = r_n_cnt;
      w_shreg_nxt     = r_shreg;
      w_dataout_nxt   = r_dataout;
      w_rx_done_nxt   = 1'b0;
      w_frame_err_nxt = r_frame_err;

      case (r_state)
         // A low line is enough to leave idle; the tick is not needed, so a
         // start right after a completed frame is never missed.
         S_IDLE: begin
            if (!r_rx_s) begin
               w_state_nxt = S_START;
               w_s_cnt_nxt = '0;
            end
         end

         // Re-check the line at the middle of the start bit; a high line
         // there means the falling edge was a glitch.
         S_START: begin
            if (bus.s_tick) begin
               if (r_s_cnt == C_MID_START) begin
                  if (!r_rx_s) begin
                     w_state_nxt = S_DATA;
                     w_s_cnt_nxt = '0;
                     w_n_cnt_nxt = '0;
                  end else begin
                     w_state_nxt = S_IDLE;
                  end
               end else begin
                  w_s_cnt_nxt = r_s_cnt + 5'd1;
               end
            end
         end

         // 16 ticks after the previous mid-point lands on the middle of the
         // next bit; bits arrive LSB first so they shift in from the top.
         S_DATA: begin
            if (bus.s_tick) begin
               if (r_s_cnt == C_BIT_LAST) begin
                  w_s_cnt_nxt = '0;
                  w_shreg_nxt = {r_rx_s, r_shreg[DBIT-1:1]};
                  if (r_n_cnt == C_LAST_BIT) begin
                     w_state_nxt = S_STOP;
                  end else begin
                     w_n_cnt_nxt = r_n_cnt + 3'd1;
                  end
               end else begin
                  w_s_cnt_nxt = r_s_cnt + 5'd1;
               end
            end
         end

         // The frame completes whatever the stop level; a low stop bit is
         // reported through frame_err rather than by dropping the byte.
         S_STOP: begin
            if (bus.s_tick) begin
               if (r_s_cnt == C_STOP_LAST) begin
                  w_dataout_nxt   = r_shreg;
                  w_frame_err_nxt = ~r_rx_s;
                  w_rx_done_nxt   = 1'b1;
                  w_state_nxt     = S_IDLE;
               end else begin
                  w_s_cnt_nxt = r_s_cnt + 5'd1;
               end
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign bus.dataout   = r_dataout;
   assign bus.rx_done   = r_rx_done;
   assign bus.frame_err = r_frame_err;
   assign bus.rx_busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_core
//   Directed bench for uart_rx_core. One instance uses DBIT=8/SB_TICK=16,
//   a second uses DBIT=7/SB_TICK=32. s_tick pulses every 4 clk, so one bit
//   lasts 64 clk. A table of frames is applied in a loop; glitch, break,
//   back-to-back, mid-frame reset and the 7-bit frame are hand sequences.
// -----------------------------------------------------------------------------
module tb_uart_rx_core;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   uart_rx_core_if #(.DBIT(8)) bus8 ();
   uart_rx_core_if #(.DBIT(7)) bus7 ();

   uart_rx_core #(.DBIT(8), .SB_TICK(16)) dut8 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus8.slave)
   );

   uart_rx_core #(.DBIT(7), .SB_TICK(32)) dut7 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus7.slave)
   );

   // 16x tick: one clk high out of every four.
   int tick_div = 0;
   always @(negedge clk) begin
      tick_div = (tick_div == 3) ? 0 : tick_div + 1;
      bus8.s_tick = (tick_div == 0);
      bus7.s_tick = (tick_div == 0);
   end

   // Capture every completed frame as {frame_err, dataout}.
   logic [8:0] cap8_q[$];
   logic [7:0] cap7_q[$];
   time        done7_t  = 0;
   int         dbl_cnt  = 0;
   int         busy_gap = 0;
   int         busy_win = 0;
   logic       prev8    = 1'b0;
   logic       prev7    = 1'b0;

   always @(negedge clk) begin
      if (bus8.rx_done === 1'b1) begin
         cap8_q.push_back({bus8.frame_err, bus8.dataout});
         if (prev8) dbl_cnt++;
      end
      if (bus7.rx_done === 1'b1) begin
         cap7_q.push_back({bus7.frame_err, bus7.dataout});
         done7_t = $time;
         if (prev7) dbl_cnt++;
      end
      prev8 = bus8.rx_done;
      prev7 = bus7.rx_done;
      if (busy_win == 8 && bus8.rx_busy !== 1'b1) busy_gap++;
      if (busy_win == 7 && bus7.rx_busy !== 1'b1) busy_gap++;
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_rx(input int which, input logic v);
      if (which == 7) bus7.rx = v;
      else            bus8.rx = v;
   endtask

   // Drives one frame starting at a negedge: start bit, nbits data bits LSB
   // first (64 clk each), then the stop level for stop_clks, then idle high.
   // The busy window covers clk 4..600 after the falling edge, inside which
   // the receiver must never be idle.
   task automatic send_frame(input int which, input logic [7:0] data, input int nbits,
                             input logic stop_bit, input int stop_clks, output time t_fall);
      int elapsed;
      set_rx(which, 1'b0);
      t_fall = $time;
      repeat (4) @(negedge clk);
      busy_win = which;
      repeat (60) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         set_rx(which, data[i]);
         repeat (64) @(negedge clk);
      end
      elapsed = 64 * (nbits + 1);
      set_rx(which, stop_bit);
      repeat (600 - elapsed) @(negedge clk);
      busy_win = 0;
      repeat (stop_clks - (600 - elapsed)) @(negedge clk);
      set_rx(which, 1'b1);
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop_bit;
      int         stop_clks;
      logic [7:0] exp_data;
      logic       exp_ferr;
   } vec_t;

   vec_t vecs[7];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      time        t0;
      logic [8:0] got;
      logic [7:0] got7;
      int         lat;

      // A bad stop bit is held only 40 clk so the line is back high before
      // the re-entered start state reaches its mid-bit check.
      vecs[0] = '{8'hA5, 1'b1, 64, 8'hA5, 1'b0};
      vecs[1] = '{8'h3C, 1'b0, 40, 8'h3C, 1'b1};
      vecs[2] = '{8'h01, 1'b1, 64, 8'h01, 1'b0};
      vecs[3] = '{8'h00, 1'b1, 64, 8'h00, 1'b0};
      vecs[4] = '{8'hFF, 1'b1, 64, 8'hFF, 1'b0};
      vecs[5] = '{8'h5A, 1'b1, 64, 8'h5A, 1'b0};
      vecs[6] = '{8'h80, 1'b1, 64, 8'h80, 1'b0};

      reset   = 1'b1;
      bus8.rx = 1'b1;
      bus7.rx = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_dataout", bus8.dataout, 8'h00);
      check("rst_rx_done", bus8.rx_done, 1'b0);
      check("rst_frame_err", bus8.frame_err, 1'b0);
      check("rst_busy", bus8.rx_busy, 1'b0);
      check("rst_dataout7", bus7.dataout, 7'h00);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      check("idle_busy", bus8.rx_busy, 1'b0);

      // Table-driven frames.
      foreach (vecs[k]) begin
         cap8_q.delete();
         busy_gap = 0;
         send_frame(8, vecs[k].data, 8, vecs[k].stop_bit, vecs[k].stop_clks, t0);
         repeat (100) @(negedge clk);
         got = (cap8_q.size() > 0) ? cap8_q[0] : 9'h1FF;
         check($sformatf("v%0d_done_cnt", k), cap8_q.size(), 1);
         check($sformatf("v%0d_data", k), got[7:0], vecs[k].exp_data);
         check($sformatf("v%0d_ferr", k), got[8], vecs[k].exp_ferr);
         check($sformatf("v%0d_data_held", k), bus8.dataout, vecs[k].exp_data);
         check($sformatf("v%0d_busy", k), busy_gap, 0);
      end

      // Glitch: 3 ticks low, then high; rejected at the mid-start check.
      cap8_q.delete();
      set_rx(8, 1'b0);
      repeat (12) @(negedge clk);
      set_rx(8, 1'b1);
      repeat (8) @(negedge clk);
      check("glitch_busy_in_start", bus8.rx_busy, 1'b1);
      repeat (20) @(negedge clk);
      check("glitch_back_idle", bus8.rx_busy, 1'b0);
      repeat (600) @(negedge clk);
      check("glitch_no_done", cap8_q.size(), 0);
      check("glitch_data_kept", bus8.dataout, 8'h80);

      // Back-to-back frames with no idle gap.
      cap8_q.delete();
      send_frame(8, 8'h5A, 8, 1'b1, 64, t0);
      send_frame(8, 8'h00, 8, 1'b1, 64, t0);
      send_frame(8, 8'hFF, 8, 1'b1, 64, t0);
      repeat (100) @(negedge clk);
      check("b2b_cnt", cap8_q.size(), 3);
      check("b2b_0", (cap8_q.size() > 0) ? cap8_q[0] : 9'h1FF, {1'b0, 8'h5A});
      check("b2b_1", (cap8_q.size() > 1) ? cap8_q[1] : 9'h1FF, {1'b0, 8'h00});
      check("b2b_2", (cap8_q.size() > 2) ? cap8_q[2] : 9'h1FF, {1'b0, 8'hFF});

      // Break: line low ~2 frame times; two bad frames, then a false start.
      cap8_q.delete();
      set_rx(8, 1'b0);
      repeat (1240) @(negedge clk);
      set_rx(8, 1'b1);
      repeat (700) @(negedge clk);
      check("brk_cnt", cap8_q.size(), 2);
      check("brk_0", (cap8_q.size() > 0) ? cap8_q[0] : 9'h0FF, {1'b1, 8'h00});
      check("brk_1", (cap8_q.size() > 1) ? cap8_q[1] : 9'h0FF, {1'b1, 8'h00});
      check("brk_busy_after", bus8.rx_busy, 1'b0);

      // Leave non-zero outputs behind, then reset during data bit 4 of 0xFF.
      cap8_q.delete();
      send_frame(8, 8'h3C, 8, 1'b0, 40, t0);
      repeat (100) @(negedge clk);
      check("pre_rst_data", bus8.dataout, 8'h3C);
      check("pre_rst_ferr", bus8.frame_err, 1'b1);
      cap8_q.delete();
      set_rx(8, 1'b0);
      repeat (64) @(negedge clk);
      set_rx(8, 1'b1);
      repeat (288) @(negedge clk);
      check("mid_rst_busy_before", bus8.rx_busy, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mid_rst_data", bus8.dataout, 8'h00);
      check("mid_rst_ferr", bus8.frame_err, 1'b0);
      check("mid_rst_done", bus8.rx_done, 1'b0);
      check("mid_rst_busy", bus8.rx_busy, 1'b0);
      repeat (400) @(negedge clk);
      check("mid_rst_no_done", cap8_q.size(), 0);
      send_frame(8, 8'h55, 8, 1'b1, 64, t0);
      repeat (100) @(negedge clk);
      check("post_rst_cnt", cap8_q.size(), 1);
      check("post_rst_frame", (cap8_q.size() > 0) ? cap8_q[0] : 9'h1FF, {1'b0, 8'h55});

      // 7 data bits, 2 stop bits (32 ticks).
      cap7_q.delete();
      busy_gap = 0;
      send_frame(7, 8'h41, 7, 1'b1, 128, t0);
      repeat (100) @(negedge clk);
      got7 = (cap7_q.size() > 0) ? cap7_q[0] : 8'hFF;
      lat  = int'((done7_t - t0) / 10);
      check("d7_cnt", cap7_q.size(), 1);
      check("d7_data", got7[6:0], 7'h41);
      check("d7_ferr", got7[7], 1'b0);
      check("d7_busy", busy_gap, 0);
      // Fall -> rx_done visible: 3 clk sync/idle, 1..4 clk to the first
      // tick, then 7+112+32 further ticks at 4 clk each.
      check("d7_latency_in_608_611", (lat >= 608 && lat <= 611), 1'b1);

      check("no_double_done", dbl_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
